// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// FSM state encodings and parameter defaults.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_DMISS = 2'd1,
        CTRL_IMISS = 2'd2
    } ctrl_state_e;

    localparam int MDU_CYCLES_DEF = 32;
    localparam int CNT_WIDTH_DEF  = 32;
    localparam int REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush outputs exchanged between the pipeline
// (master) and the stall/flush controller (slave).
interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) ();
    logic                  id_nop;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic                  id_uses_rt;
    logic                  id_mdu_use;
    logic                  id_redirect;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rt_addr;
    logic                  ex_mdu_start;
    logic                  icache_miss;
    logic                  icache_ready;
    logic                  dcache_miss;
    logic                  dcache_ready;
    logic                  pc_stall;
    logic                  cu_stall;
    logic                  cu_flush;
    logic                  idex_flush;
    logic                  exmem_stall;
    logic                  mdu_busy;
    logic [CNT_WIDTH-1:0]  stall_count;

    modport master (
        output id_nop, id_rs_addr, id_rt_addr, id_uses_rt, id_mdu_use, id_redirect,
               ex_mem_read, ex_rt_addr, ex_mdu_start,
               icache_miss, icache_ready, dcache_miss, dcache_ready,
        input  pc_stall, cu_stall, cu_flush, idex_flush, exmem_stall, mdu_busy, stall_count
    );

    modport slave (
        input  id_nop, id_rs_addr, id_rt_addr, id_uses_rt, id_mdu_use, id_redirect,
               ex_mem_read, ex_rt_addr, ex_mdu_start,
               icache_miss, icache_ready, dcache_miss, dcache_ready,
        output pc_stall, cu_stall, cu_flush, idex_flush, exmem_stall, mdu_busy, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl_mdu_busy_timer.sv
// Tracks multiply/divide occupancy: reloads on start, counts down to zero,
// and holds its value while the back end is frozen.
module mdu_busy_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic freeze,
    output logic busy
);
    localparam int W = (MDU_CYCLES > 2) ? $clog2(MDU_CYCLES) : 1;
    localparam logic [W-1:0] RELOAD = W'(MDU_CYCLES - 1);

    logic [W-1:0] count;

    // A start while frozen is dropped; the held EX instruction reissues it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!freeze) begin
            if (start) begin
                count <= RELOAD;
            end else if (count != '0) begin
                count <= count - W'(1);
            end
        end
    end

    assign busy = (count != '0);
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the pipeline front end: cache-miss FSM, load-use
// and MDU hazard stalls, deferred redirect flush and a saturating stall counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input logic           clk,
    input logic           reset_n,
    pipeline_ctrl_if.slave bus
);
    localparam logic [REG_ADDR_W-1:0] ADDR_ZERO = '0;

    ctrl_state_e          state;
    logic                 flush_pending;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 busy;
    logic                 load_use;
    logic                 hazard;
    logic                 pc_stall;
    logic                 cu_stall;
    logic                 cu_flush;
    logic                 idex_flush;
    logic                 exmem_stall;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign load_use = bus.ex_mem_read && (bus.ex_rt_addr != ADDR_ZERO) && !bus.id_nop &&
                      ((bus.ex_rt_addr == bus.id_rs_addr) ||
                       (bus.id_uses_rt && (bus.ex_rt_addr == bus.id_rt_addr)));
    assign hazard = load_use || (bus.id_mdu_use && busy);

    // Mealy outputs; a stall always suppresses the flush so the redirect waits.
    always_comb begin
        pc_stall    = 1'b0;
        cu_stall    = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        case (state)
            CTRL_DMISS: begin
                pc_stall    = !bus.dcache_ready;
                cu_stall    = !bus.dcache_ready;
                exmem_stall = !bus.dcache_ready;
            end
            CTRL_IMISS: begin
                pc_stall = !bus.icache_ready;
            end
            default: begin
                pc_stall   = hazard;
                cu_stall   = hazard;
                idex_flush = hazard;
            end
        endcase
        cu_flush = !cu_stall && (bus.id_redirect || flush_pending ||
                                 (state == CTRL_IMISS && !bus.icache_ready));
        if (!reset_n) begin
            pc_stall    = 1'b0;
            cu_stall    = 1'b0;
            cu_flush    = 1'b1;
            idex_flush  = 1'b1;
            exmem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= CTRL_RUN;
            flush_pending <= 1'b0;
            count_q       <= '0;
        end else begin
            flush_pending <= cu_stall && (bus.id_redirect || flush_pending);
            if (pc_stall) begin
                count_q <= sat_inc(count_q);
            end
            case (state)
                CTRL_RUN: begin
                    if (bus.dcache_miss)      state <= CTRL_DMISS;
                    else if (bus.icache_miss) state <= CTRL_IMISS;
                end
                CTRL_DMISS: begin
                    if (bus.dcache_ready) state <= bus.icache_miss ? CTRL_IMISS : CTRL_RUN;
                end
                CTRL_IMISS: begin
                    if (bus.dcache_miss)       state <= CTRL_DMISS;
                    else if (bus.icache_ready) state <= CTRL_RUN;
                end
                default: state <= CTRL_RUN;
            endcase
        end
    end

    mdu_busy_timer #(.MDU_CYCLES(MDU_CYCLES)) u_mdu_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (bus.ex_mdu_start),
        .freeze (exmem_stall),
        .busy   (busy)
    );

    assign bus.pc_stall    = pc_stall;
    assign bus.cu_stall    = cu_stall;
    assign bus.cu_flush    = cu_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_stall = exmem_stall;
    assign bus.mdu_busy    = busy;
    assign bus.stall_count = count_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, directed multi-cycle sequences and
// random stimulus against a cycle-level behavioural model.
module tb_pipeline_ctrl;
    localparam int MDU_C = 8;
    localparam int CW    = 4;
    localparam int AW    = 5;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.REG_ADDR_W(AW), .CNT_WIDTH(CW)) bus ();

    pipeline_ctrl #(.MDU_CYCLES(MDU_C), .CNT_WIDTH(CW), .REG_ADDR_W(AW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int busy_n  = 0;

    // Model: which miss is outstanding, MDU cycles left, pending redirect, stall cycles.
    bit m_dmiss, m_imiss, m_pend;
    int m_mdu, m_cnt;
    bit e_pc, e_cu, e_fl, e_idex, e_ex;

    typedef struct {
        logic       nop;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       redir;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_outs();
        bit lu;
        e_pc = 0; e_cu = 0; e_fl = 0; e_idex = 0; e_ex = 0;
        if (!reset_n) begin
            e_fl = 1; e_idex = 1;
            return;
        end
        lu = bus.ex_mem_read && bus.ex_rt_addr != 0 && !bus.id_nop &&
             (bus.ex_rt_addr == bus.id_rs_addr || (bus.id_uses_rt && bus.ex_rt_addr == bus.id_rt_addr));
        if (m_dmiss) begin
            e_pc = !bus.dcache_ready; e_cu = e_pc; e_ex = e_pc;
        end else if (m_imiss) begin
            e_pc = !bus.icache_ready;
        end else begin
            e_pc = lu || (bus.id_mdu_use && m_mdu > 0);
            e_cu = e_pc; e_idex = e_pc;
        end
        e_fl = !e_cu && (bus.id_redirect || m_pend || (m_imiss && !bus.icache_ready));
    endfunction

    task automatic check_model();
        logic [9:0] act, exp;
        model_outs();
        act = {bus.pc_stall, bus.cu_stall, bus.cu_flush, bus.idex_flush, bus.exmem_stall,
               bus.mdu_busy, bus.stall_count};
        exp = {e_pc, e_cu, e_fl, e_idex, e_ex, (reset_n && m_mdu > 0),
               reset_n ? 4'(m_cnt) : 4'd0};
        check("model", 32'(act), 32'(exp));
    endtask

    task automatic model_step();
        bit d, i;
        model_outs();
        if (!reset_n) begin
            m_dmiss = 0; m_imiss = 0; m_pend = 0; m_mdu = 0; m_cnt = 0;
            return;
        end
        if (e_pc && m_cnt < CMAX) m_cnt++;
        m_pend = e_cu && (bus.id_redirect || m_pend);
        if (!e_ex) begin
            if (bus.ex_mdu_start) m_mdu = MDU_C - 1;
            else if (m_mdu > 0) m_mdu--;
        end
        d = m_dmiss; i = m_imiss;
        if (m_dmiss) begin
            if (bus.dcache_ready) begin d = 0; i = bus.icache_miss; end
        end else if (m_imiss) begin
            if (bus.dcache_miss) begin d = 1; i = 0; end
            else if (bus.icache_ready) i = 0;
        end else begin
            if (bus.dcache_miss) d = 1;
            else if (bus.icache_miss) i = 1;
        end
        m_dmiss = d; m_imiss = i;
    endtask

    task automatic half();
        @(negedge clk);
        check_model();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick();
        half();
        finish_cycle();
    endtask

    task automatic set_idle();
        bus.id_nop = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_uses_rt = 0;
        bus.id_mdu_use = 0; bus.id_redirect = 0; bus.ex_mem_read = 0; bus.ex_rt_addr = 0;
        bus.ex_mdu_start = 0; bus.icache_miss = 0; bus.icache_ready = 0;
        bus.dcache_miss = 0; bus.dcache_ready = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        int n;
        tbl[0]  = '{1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 4'b1101};
        tbl[1]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000};
        tbl[2]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 4'b0000};
        tbl[3]  = '{1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 4'b1101};
        tbl[4]  = '{1'b0, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 4'b0000};
        tbl[5]  = '{1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 4'b0000};
        tbl[6]  = '{1'b0, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 4'b1101};
        tbl[7]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0010};
        tbl[8]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000};
        tbl[9]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 4'b0010};
        tbl[10] = '{1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 4'b0000};

        set_idle();
        reset_n = 0;
        half();
        check("reset_outs", 32'({bus.pc_stall, bus.cu_stall, bus.cu_flush, bus.idex_flush,
                                 bus.exmem_stall, bus.mdu_busy}), 32'b001100);
        check("reset_cnt", 32'(bus.stall_count), 32'd0);
        finish_cycle();
        reset_n = 1;

        // Single-cycle load-use and redirect vectors, all in RUN.
        for (int i = 0; i < 11; i++) begin
            bus.id_nop = tbl[i].nop; bus.id_rs_addr = tbl[i].rs; bus.id_rt_addr = tbl[i].rt;
            bus.id_uses_rt = tbl[i].uses_rt; bus.ex_mem_read = tbl[i].mem_read;
            bus.ex_rt_addr = tbl[i].ex_rt; bus.id_redirect = tbl[i].redir;
            half();
            check($sformatf("vec%0d", i),
                  32'({bus.pc_stall, bus.cu_stall, bus.cu_flush, bus.idex_flush}), 32'(tbl[i].exp));
            finish_cycle();
        end

        // D-miss with a redirect arriving mid-miss.
        do_reset();
        bus.dcache_miss = 1;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.id_redirect = (i == 2);
            half();
            check($sformatf("dmiss_hold%0d", i), 32'({bus.cu_stall, bus.cu_flush}), 32'b10);
            finish_cycle();
        end
        bus.id_redirect = 0; bus.dcache_miss = 0; bus.dcache_ready = 1;
        half();
        check("dmiss_release_flush", 32'({bus.cu_stall, bus.cu_flush}), 32'b01);
        check("dmiss_stall_count", 32'(bus.stall_count), 32'd10);
        finish_cycle();
        bus.dcache_ready = 0;
        half();
        check("dmiss_flush_once", 32'(bus.cu_flush), 32'd0);
        finish_cycle();

        // Simultaneous I- and D-miss: D side first, then I side.
        bus.icache_miss = 1; bus.dcache_miss = 1;
        tick();
        bus.dcache_miss = 0;
        for (int i = 0; i < 3; i++) begin
            half();
            check("both_dmiss", 32'({bus.pc_stall, bus.cu_stall, bus.cu_flush, bus.exmem_stall}), 32'b1101);
            finish_cycle();
        end
        bus.dcache_ready = 1;
        half();
        check("both_dready", 32'({bus.pc_stall, bus.cu_stall, bus.cu_flush, bus.exmem_stall}), 32'b0000);
        finish_cycle();
        bus.dcache_ready = 0;
        for (int i = 0; i < 3; i++) begin
            half();
            check("both_imiss", 32'({bus.pc_stall, bus.cu_stall, bus.cu_flush, bus.exmem_stall}), 32'b1010);
            finish_cycle();
        end
        bus.icache_miss = 0; bus.icache_ready = 1;
        half();
        check("both_iready", 32'({bus.pc_stall, bus.cu_flush}), 32'b00);
        finish_cycle();
        bus.icache_ready = 0;
        half();
        check("both_run", 32'({bus.pc_stall, bus.cu_stall, bus.cu_flush, bus.exmem_stall}), 32'b0000);
        finish_cycle();

        // MDU occupancy stall, then occupancy stretched by a frozen back end.
        do_reset();
        bus.ex_mdu_start = 1;
        tick();
        bus.ex_mdu_start = 0; bus.id_mdu_use = 1;
        done = 0; n = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            half();
            if (bus.pc_stall) n++; else done = 1;
            finish_cycle();
        end
        check("mdu_stall_done", 32'(done), 32'd1);
        check("mdu_stall_len", 32'(n), 32'(MDU_C - 1));
        bus.id_mdu_use = 0; bus.ex_mdu_start = 1;
        tick();
        bus.ex_mdu_start = 0;
        busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            bus.dcache_miss = (i == 2);
            bus.dcache_ready = (i == 7);
            half();
            if (bus.mdu_busy) busy_n++;
            finish_cycle();
        end
        bus.dcache_miss = 0; bus.dcache_ready = 0;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            half();
            if (bus.mdu_busy) busy_n++; else done = 1;
            finish_cycle();
        end
        check("mdu_freeze_done", 32'(done), 32'd1);
        check("mdu_freeze_len", 32'(busy_n), 32'(MDU_C - 1 + 4));

        // Asynchronous reset in the middle of a D-miss.
        do_reset();
        bus.dcache_miss = 1;
        tick();
        bus.dcache_miss = 0;
        tick();
        tick();
        reset_n = 0;
        #1;
        check("areset_outs", 32'({bus.pc_stall, bus.cu_stall, bus.cu_flush, bus.idex_flush,
                                  bus.exmem_stall}), 32'b00110);
        check("areset_cnt", 32'(bus.stall_count), 32'd0);
        tick();
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            half();
            check("areset_nostall", 32'(bus.pc_stall), 32'd0);
            finish_cycle();
        end

        // Long miss saturates the 4-bit counter.
        do_reset();
        bus.dcache_miss = 1;
        tick();
        bus.dcache_miss = 0;
        for (int i = 0; i < 20; i++) tick();
        half();
        check("sat_count", 32'(bus.stall_count), 32'(CMAX));
        finish_cycle();
        bus.dcache_ready = 1;
        tick();
        bus.dcache_ready = 0;

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            bus.id_nop       = ($urandom_range(0, 7) == 0);
            bus.id_rs_addr   = 5'($urandom_range(0, 3));
            bus.id_rt_addr   = 5'($urandom_range(0, 3));
            bus.id_uses_rt   = 1'($urandom_range(0, 1));
            bus.id_mdu_use   = ($urandom_range(0, 2) == 0);
            bus.id_redirect  = ($urandom_range(0, 7) == 0);
            bus.ex_mem_read  = ($urandom_range(0, 2) == 0);
            bus.ex_rt_addr   = 5'($urandom_range(0, 3));
            bus.ex_mdu_start = ($urandom_range(0, 9) == 0);
            bus.icache_miss  = ($urandom_range(0, 9) == 0);
            bus.icache_ready = ($urandom_range(0, 3) == 0);
            bus.dcache_miss  = ($urandom_range(0, 9) == 0);
            bus.dcache_ready = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline front end. It generates cu_stall and cu_flush for the IF/ID register, and hold/bubble controls for the PC, ID/EX and EX/MEM/WB stages. Sources are load-use hazards, I-cache and D-cache misses, multiply/divide occupancy and ID-stage redirects (taken branch or jump). It guarantees that cu_stall and cu_flush are never asserted together, so a redirect is never lost.

Parameters:
MDU_CYCLES, 32, multiply/divide latency in cycles after ex_mdu_start.
CNT_WIDTH, 32, width of the stall performance counter.
REG_ADDR_W, 5, register address width (matches `REG_ADDR_BUS).

Ports:
clk  in  1  pipeline clock; state updates on posedge, pipeline registers sample outputs on negedge.
reset_n  in  1  asynchronous, active-low reset.
id_nop  in  1  ID slot holds a bubble.
id_rs_addr  in  REG_ADDR_W  rs of the ID instruction.
id_rt_addr  in  REG_ADDR_W  rt of the ID instruction.
id_uses_rt  in  1  ID instruction reads rt.
id_mdu_use  in  1  ID instruction is mfhi/mflo/mult/div.
id_redirect  in  1  single-cycle pulse: branch taken or jump resolved in ID.
ex_mem_read  in  1  EX instruction is a load.
ex_rt_addr  in  REG_ADDR_W  destination of the EX load.
ex_mdu_start  in  1  MDU operation issued from EX this cycle.
icache_miss  in  1  fetch missed.
icache_ready  in  1  refill complete.
dcache_miss  in  1  MEM access missed.
dcache_ready  in  1  refill complete.
pc_stall  out  1  hold PC.
cu_stall  out  1  hold IF/ID.
cu_flush  out  1  load bubble into IF/ID.
idex_flush  out  1  load bubble into ID/EX.
exmem_stall  out  1  freeze EX/MEM and MEM/WB.
mdu_busy  out  1  MDU counter non-zero.
stall_count  out  CNT_WIDTH  cycles with pc_stall=1, saturating.

Behaviour:
- FSM states: RUN, DMISS, IMISS (registered). Outputs are Mealy, combinational from state plus current inputs, so they are stable before the negedge sample.
- Reset (reset_n=0, asynchronous):
  - state=RUN; MDU counter, flush_pending and stall_count cleared.
  - Outputs: pc_stall=0, cu_stall=0, cu_flush=1, idex_flush=1, exmem_stall=0, mdu_busy=0, stall_count=0.
  - Reset asserted mid-miss or mid-MDU aborts the operation. There is no replay.
- RUN transitions: dcache_miss -> DMISS; else icache_miss -> IMISS; else stay.
- DMISS:
  - Asserts pc_stall, cu_stall, exmem_stall; idex_flush=0 (ID/EX holds via exmem_stall).
  - On dcache_ready: next state IMISS if icache_miss=1, else RUN. Outputs deassert in the cycle ready is seen.
- IMISS:
  - Asserts pc_stall and cu_flush (bubble enters IF/ID); back end keeps running; cu_stall=0.
  - dcache_miss during IMISS -> DMISS (priority to D-side). On icache_ready -> RUN.
- Load-use hazard (RUN only). Condition: ex_mem_read & ex_rt_addr!=0 & !id_nop & (ex_rt_addr==id_rs_addr | (id_uses_rt & ex_rt_addr==id_rt_addr)).
  - Response: pc_stall=1, cu_stall=1, idex_flush=1 for exactly that cycle.
- MDU timer:
  - ex_mdu_start loads MDU_CYCLES-1; decrements each cycle to 0; mdu_busy = (count!=0).
  - ex_mdu_start while busy reloads the counter.
  - Timer is frozen while exmem_stall=1.
  - id_mdu_use & mdu_busy in RUN: same response as load-use (pc_stall, cu_stall, idex_flush).
- Redirect handling:
  - id_redirect with cu_stall=0: cu_flush=1 that cycle.
  - id_redirect with cu_stall=1: set flush_pending. cu_flush is asserted on the first cycle cu_stall=0, then flush_pending clears.
  - A pulse and a pending flush in the same cycle produce one flush.
- Invariant: cu_stall & cu_flush == 0 always. Stall wins; the flush is deferred.
- stall_count increments on each posedge with pc_stall=1 and saturates at all-ones.

Decomposition:
- Shared header common.vh: FSM state encodings (CTRL_RUN, CTRL_DMISS, CTRL_IMISS), `REG_ADDR_BUS, MDU_CYCLES default.
- One sub-module: mdu_busy_timer (load/decrement/freeze counter, busy output).
- Hazard compare and FSM stay in pipeline_ctrl.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rt_addr=5, id_rs_addr=5 -> pc_stall=cu_stall=idex_flush=1 for one cycle, then all 0; ex_rt_addr=0 -> no stall.
2. D-miss with redirect: dcache_miss=1 for 10 cycles, id_redirect pulse in cycle 3 -> cu_stall=1 and cu_flush=0 during the miss; cu_flush=1 exactly in the cycle after dcache_ready; stall_count=10.
3. Simultaneous misses: icache_miss=dcache_miss=1 -> DMISS first; after dcache_ready, IMISS with cu_flush=1, cu_stall=0 until icache_ready.
4. MDU: ex_mdu_start, then id_mdu_use=1 -> stalls for MDU_CYCLES-1 cycles; a 4-cycle dcache miss inside extends the stall by 4 cycles.
5. Reset mid-DMISS: reset_n=0 -> immediately state RUN, stall_count=0, cu_flush=idex_flush=1; after release, no stall without new misses.
6. Saturation: preload via long stall with CNT_WIDTH=4 -> stall_count stops at 15.
